// File: rtl/jt12_adpcm_interp_mc.sv
// Multichannel linear interpolator for ADPCM decoder outputs.
// One shared shift-add multiplier computes per-channel step sizes in round-robin order.
module jt12_adpcm_interp_mc #(
    parameter int DW = 16,
    parameter int CH = 2,
    parameter int MW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             tick,
    input  logic [CH-1:0]    ld,
    input  logic [CH*DW-1:0] din,
    input  logic [CH*MW-1:0] rate,
    input  logic [CH-1:0]    interp_en,
    output logic [CH*DW-1:0] pcm_out,
    output logic [CH-1:0]    step_vld,
    output logic             busy
);

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int BW = (MW > 1) ? $clog2(MW) : 1;
    localparam int PW = DW + 1 + MW;

    localparam logic signed [DW+1:0] SMAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] SMIN = {3'b111, {(DW-1){1'b0}}};

    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_nx;

    logic signed [DW:0]   cur     [CH];
    logic signed [DW-1:0] target  [CH];
    logic signed [DW:0]   diff    [CH];
    logic        [DW:0]   step    [CH];
    logic [CH-1:0]        sign, pending, vld;

    logic signed [DW-1:0] din_c   [CH];
    logic signed [DW:0]   diff_nx [CH];
    logic        [DW:0]   mag     [CH];
    logic signed [DW+1:0] nxt     [CH];
    logic signed [DW+1:0] tgt_x   [CH];
    logic signed [DW:0]   cur_nx  [CH];

    logic [CW-1:0] last, owner, cand;
    logic          cand_ok, grant, abort, last_bit, done;
    logic [PW-1:0] acc, mcand, prod_nx;
    logic [MW-1:0] mplier;
    logic [BW-1:0] cnt;

    // Per-channel datapath: new diff, magnitude and the clamped/saturated next value
    always_comb begin
        din_c   = '{default: '0};
        diff_nx = '{default: '0};
        mag     = '{default: '0};
        nxt     = '{default: '0};
        tgt_x   = '{default: '0};
        cur_nx  = '{default: '0};
        pcm_out = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            din_c[c]   = din[c*DW +: DW];
            diff_nx[c] = {din_c[c][DW-1], din_c[c]} - {target[c][DW-1], target[c]};
            mag[c]     = diff[c][DW] ? -diff[c] : diff[c];
            tgt_x[c]   = {{2{target[c][DW-1]}}, target[c]};
            nxt[c]     = sign[c] ? {cur[c][DW], cur[c]} - {1'b0, step[c]}
                                 : {cur[c][DW], cur[c]} + {1'b0, step[c]};
            if (sign[c] ? (nxt[c] <= tgt_x[c]) : (nxt[c] >= tgt_x[c]))
                cur_nx[c] = {target[c][DW-1], target[c]};
            else if (nxt[c] > SMAX)
                cur_nx[c] = SMAX[DW:0];
            else if (nxt[c] < SMIN)
                cur_nx[c] = SMIN[DW:0];
            else
                cur_nx[c] = nxt[c][DW:0];
            pcm_out[c*DW +: DW] = cur[c][DW-1:0];
        end
    end

    // Round-robin: search above the last grant first, then wrap to the bottom
    always_comb begin
        cand    = '0;
        cand_ok = 1'b0;
        for (int unsigned j = 0; j < CH; j++) begin
            if (!cand_ok && pending[j] && j > 32'(last)) begin
                cand    = CW'(j);
                cand_ok = 1'b1;
            end
        end
        for (int unsigned j = 0; j < CH; j++) begin
            if (!cand_ok && pending[j] && j <= 32'(last)) begin
                cand    = CW'(j);
                cand_ok = 1'b1;
            end
        end
    end

    // A load on the candidate in the same clk would latch a stale diff, so the grant waits
    always_comb begin
        prod_nx  = acc + (mplier[0] ? mcand : '0);
        last_bit = cen && (cnt == BW'(MW-1));
        abort    = (state == MUL) && ld[owner];
        done     = (state == MUL) && last_bit && !ld[owner];
        grant    = (state == IDLE) && cand_ok && !ld[cand];
        state_nx = state;
        case (state)
            IDLE: if (grant) state_nx = MUL;
            MUL:  if (abort || last_bit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last   <= CW'(CH-1);
            owner  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (grant) begin
            owner  <= cand;
            last   <= cand;
            acc    <= '0;
            mcand  <= PW'(mag[cand]);
            mplier <= rate[cand*MW +: MW];
            cnt    <= '0;
        end else if (state == MUL && cen) begin
            acc    <= prod_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < CH; c++) begin
                cur[c]    <= '0;
                target[c] <= '0;
                diff[c]   <= '0;
                step[c]   <= '0;
            end
            sign    <= '0;
            pending <= '0;
            vld     <= '0;
        end else begin
            for (int unsigned c = 0; c < CH; c++) begin
                if (ld[c]) begin
                    target[c] <= din_c[c];
                    step[c]   <= '0;
                    if (interp_en[c]) begin
                        cur[c]     <= {target[c][DW-1], target[c]};
                        diff[c]    <= diff_nx[c];
                        sign[c]    <= diff_nx[c][DW];
                        vld[c]     <= 1'b0;
                        pending[c] <= 1'b1;
                    end else begin
                        cur[c]     <= {din_c[c][DW-1], din_c[c]};
                        sign[c]    <= 1'b0;
                        vld[c]     <= 1'b1;
                        pending[c] <= 1'b0;
                    end
                end else begin
                    if (grant && cand == CW'(c))
                        pending[c] <= 1'b0;
                    if (done && owner == CW'(c)) begin
                        step[c] <= prod_nx[MW +: DW+1];
                        vld[c]  <= 1'b1;
                    end
                    if (tick && vld[c])
                        cur[c] <= cur_nx[c];
                end
            end
        end
    end

    assign step_vld = vld;
    assign busy     = (state == MUL);

endmodule

// File: tb/tb_jt12_adpcm_interp_mc.sv
// Directed and randomized bench for jt12_adpcm_interp_mc against an arithmetic reference model.
module tb_jt12_adpcm_interp_mc;

    localparam int DW = 16;
    localparam int CH = 2;
    localparam int MW = 16;

    logic             clk = 1'b0;
    logic             rst, cen, tick, busy;
    logic [CH-1:0]    ld, interp_en, step_vld;
    logic [CH*DW-1:0] din, pcm_out;
    logic [CH*MW-1:0] rate;

    always #5 clk = ~clk;

    jt12_adpcm_interp_mc #(.DW(DW), .CH(CH), .MW(MW)) dut (
        .clk(clk), .rst(rst), .cen(cen), .tick(tick), .ld(ld), .din(din),
        .rate(rate), .interp_en(interp_en), .pcm_out(pcm_out),
        .step_vld(step_vld), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: plain integers per channel
    int m_cur [CH];
    int m_tgt [CH];
    int m_step[CH];
    bit m_sign[CH];
    bit m_vld [CH];
    bit m_pend[CH];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] pcm(input int c);
        return $signed(pcm_out[c*DW +: DW]);
    endfunction

    task automatic clk1();
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_cur[c] = 0; m_tgt[c] = 0; m_step[c] = 0;
            m_sign[c] = 0; m_vld[c] = 0; m_pend[c] = 0;
        end
    endtask

    task automatic drive_ld(input int c, input int v, input int r, input bit en);
        int d;
        din[c*DW +: DW]  = 16'(v);
        rate[c*MW +: MW] = 16'(r);
        interp_en[c]     = en;
        ld[c]            = 1'b1;
        if (en) begin
            d          = v - m_tgt[c];
            m_cur[c]   = m_tgt[c];
            m_tgt[c]   = v;
            m_sign[c]  = (d < 0);
            m_step[c]  = int'((longint'(d < 0 ? -d : d) * longint'(r & 'hFFFF)) / 65536);
            m_vld[c]   = 0;
            m_pend[c]  = 1;
        end else begin
            m_cur[c]   = v;
            m_tgt[c]   = v;
            m_step[c]  = 0;
            m_sign[c]  = 0;
            m_vld[c]   = 1;
            m_pend[c]  = 0;
        end
    endtask

    task automatic model_tick(input int c);
        int n;
        if (!m_vld[c]) return;
        n = m_sign[c] ? m_cur[c] - m_step[c] : m_cur[c] + m_step[c];
        if (m_sign[c] ? (n <= m_tgt[c]) : (n >= m_tgt[c])) m_cur[c] = m_tgt[c];
        else if (n > 32767)  m_cur[c] = 32767;
        else if (n < -32768) m_cur[c] = -32768;
        else                 m_cur[c] = n;
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("%s_pcm%0d", tag, c), pcm(c), m_cur[c]);
            chk($sformatf("%s_vld%0d", tag, c), step_vld[c], m_vld[c]);
        end
    endtask

    task automatic do_tick(input string tag);
        tick = 1'b1;
        clk1();
        tick = 1'b0;
        for (int c = 0; c < CH; c++) model_tick(c);
        check_all(tag);
    endtask

    // Called one clk after the load; rate is scrambled mid-multiply and must be ignored
    task automatic wait_rise(input int c, input int exp_lat, input string tag);
        int n = 1;
        while (!step_vld[c] && n < 60) begin
            clk1();
            n++;
            if (n == 5)  rate[c*MW +: MW] = 16'($urandom);
            if (n == 10) chk({tag, "_busy"}, busy, 1);
        end
        chk({tag, "_lat"}, n, exp_lat);
        m_vld[c]  = 1;
        m_pend[c] = 0;
        check_all(tag);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int n, t0, t1, idle, mask, k, v;
        bit tk, en;
        logic [CH-1:0] want;

        rst = 1'b1; cen = 1'b1; tick = 1'b0; ld = '1; interp_en = '1;
        din = CH*DW'($urandom); rate = CH*MW'($urandom);
        model_reset();

        // Reset held for 3 clk with loads active
        repeat (3) clk1();
        rst = 1'b0; ld = '0;
        check_all("rst");
        chk("rst_busy", busy, 0);
        clk1();
        check_all("rst_after");
        chk("rst_after_busy", busy, 0);

        // Basic upward ramp
        drive_ld(0, 1000, 'h1000, 1);
        clk1(); ld = '0;
        check_all("ramp_snap");
        wait_rise(0, 18, "ramp");
        for (int i = 0; i < 16; i++) do_tick("ramp_t");
        chk("ramp_16", pcm(0), 992);
        do_tick("ramp_t17");
        chk("ramp_17", pcm(0), 1000);
        repeat (2) do_tick("ramp_hold");
        chk("ramp_hold_v", pcm(0), 1000);

        // Negative ramp
        drive_ld(0, -1000, 'h1000, 1);
        clk1(); ld = '0;
        check_all("neg_snap");
        chk("neg_snap_v", pcm(0), 1000);
        wait_rise(0, 18, "neg");
        do_tick("neg_t1");
        chk("neg_1", pcm(0), 875);
        for (int i = 0; i < 15; i++) do_tick("neg_t");
        chk("neg_16", pcm(0), -1000);
        repeat (2) do_tick("neg_hold");
        chk("neg_hold_v", pcm(0), -1000);

        // Arbitration from a fresh reset: ch0 first, ch1 one IDLE clk later
        pulse_reset();
        drive_ld(0, 500, 'h8000, 1);
        drive_ld(1, -300, 'h8000, 1);
        clk1(); ld = '0;
        check_all("arb_snap");
        n = 1; t0 = 0; t1 = 0; idle = 0;
        while ((t0 == 0 || t1 == 0) && n < 80) begin
            clk1();
            n++;
            if (step_vld[0] && t0 == 0) t0 = n;
            if (step_vld[1] && t1 == 0) t1 = n;
            if (t0 != 0 && t1 == 0 && !busy) idle++;
        end
        chk("arb_t0", t0, 18);
        chk("arb_t1", t1, 35);
        chk("arb_idle", idle, 1);
        m_vld[0] = 1; m_vld[1] = 1; m_pend[0] = 0; m_pend[1] = 0;
        check_all("arb_done");
        repeat (3) do_tick("arb_t");

        // Bypass channel 1
        drive_ld(1, 32767, 0, 0);
        clk1(); ld = '0;
        check_all("byp");
        chk("byp_v", pcm(1), 32767);
        repeat (2) do_tick("byp_t");
        chk("byp_hold", pcm(1), 32767);

        // Abort: reload ch0 while its step is being multiplied
        drive_ld(0, 2000, 'h2000, 1);
        clk1(); ld = '0;
        n = 1;
        while (n < 6) begin
            clk1();
            n++;
        end
        chk("abort_busy", busy, 1);
        chk("abort_vld", step_vld[0], 0);
        drive_ld(0, -2000, 'h2000, 1);
        clk1(); ld = '0;
        check_all("abort_snap");
        wait_rise(0, 18, "abort");
        repeat (2) do_tick("abort_t");

        // Full-scale swing: -32768 then +32767
        drive_ld(0, -32768, 'hFFFF, 1);
        clk1(); ld = '0;
        wait_rise(0, 18, "satn");
        n = 0;
        while (m_cur[0] != m_tgt[0] && n < 10) begin
            do_tick("satn_t");
            n++;
        end
        chk("satn_v", pcm(0), -32768);
        drive_ld(0, 32767, 'hFFFF, 1);
        clk1(); ld = '0;
        wait_rise(0, 18, "satp");
        do_tick("satp_t1");
        chk("satp_nowrap", pcm(0) > 0, 1);
        do_tick("satp_t2");
        chk("satp_v", pcm(0), 32767);

        // Reset in the middle of a multiply
        drive_ld(0, 100, 'h4000, 1);
        clk1(); ld = '0;
        repeat (4) clk1();
        pulse_reset();
        check_all("rstmul");
        chk("rstmul_busy", busy, 0);
        repeat (20) clk1();
        check_all("rstmul_later");
        chk("rstmul_later_busy", busy, 0);

        // Randomized loads, ticks coincident with loads, gated cen
        for (int it = 0; it < 40; it++) begin
            mask = $urandom_range(1, 3);
            tk   = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < CH; c++) begin
                if (mask[c]) begin
                    v  = int'($urandom_range(0, 65535)) - 32768;
                    en = ($urandom_range(0, 3) != 0);
                    drive_ld(c, v, int'($urandom_range(0, 65535)), en);
                end
            end
            tick = tk;
            clk1();
            ld = '0; tick = 1'b0;
            if (tk)
                for (int c = 0; c < CH; c++)
                    if (!mask[c]) model_tick(c);
            check_all($sformatf("rnd%0d_ld", it));
            for (int c = 0; c < CH; c++) want[c] = m_vld[c] | m_pend[c];
            n = 0;
            while (step_vld !== want && n < 600) begin
                cen = ($urandom_range(0, 3) != 0);
                clk1();
                n++;
            end
            cen = 1'b1;
            for (int c = 0; c < CH; c++) begin
                if (m_pend[c]) begin
                    m_vld[c]  = 1;
                    m_pend[c] = 0;
                end
            end
            check_all($sformatf("rnd%0d_vld", it));
            k = $urandom_range(0, 4);
            for (int i = 0; i < k; i++) do_tick($sformatf("rnd%0d_t", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
